// File: rtl/rx_mem_rd_cpl_pkg.sv
// Shared TLP codes, request field layout and FSM encoding for the BAR0
// register-read completer.
package rx_mem_rd_cpl_pkg;

    localparam logic [6:0] MRD32                = 7'b00_00000;
    localparam logic [6:0] MRD64                = 7'b01_00000;
    localparam logic [6:0] CPL_W_DATA_FMT_TYPE  = 7'b10_01010;
    localparam logic [6:0] CPL_NO_DATA_FMT_TYPE = 7'b00_01010;

    localparam logic [2:0] SC = 3'b000;
    localparam logic [2:0] UR = 3'b001;

    localparam logic [6:0] BAR0_MASK = 7'b1111110;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR2,
        ST_RD,
        ST_WAIT,
        ST_REQ,
        ST_B0,
        ST_B1
    } state_t;

    typedef struct packed {
        logic [2:0]  tc;
        logic [1:0]  attr;
        logic [9:0]  length;
        logic [15:0] req_id;
        logic [7:0]  tag;
        logic [3:0]  first_be;
        logic        is_64;
    } req_fields_t;

    function automatic logic [1:0] first_be_index(input logic [3:0] be);
        if (be[0])      return 2'd0;
        else if (be[1]) return 2'd1;
        else if (be[2]) return 2'd2;
        else if (be[3]) return 2'd3;
        else            return 2'd0;
    endfunction

endpackage

// File: rtl/rx_mem_rd_cpl_if.sv
// TRN transmit path towards the tx arbiter, including the request/grant pair.
interface rx_mem_rd_cpl_if;

    logic        tx_req;
    logic        tx_gnt;
    logic [63:0] trn_td;
    logic [7:0]  trn_trem_n;
    logic        trn_tsof_n;
    logic        trn_teof_n;
    logic        trn_tsrc_rdy_n;
    logic        trn_tdst_rdy_n;
    logic        trn_tdst_dsc_n;

    modport master (
        output tx_req,
        output trn_td,
        output trn_trem_n,
        output trn_tsof_n,
        output trn_teof_n,
        output trn_tsrc_rdy_n,
        input  tx_gnt,
        input  trn_tdst_rdy_n,
        input  trn_tdst_dsc_n
    );

    modport slave (
        input  tx_req,
        input  trn_td,
        input  trn_trem_n,
        input  trn_tsof_n,
        input  trn_teof_n,
        input  trn_tsrc_rdy_n,
        output tx_gnt,
        output trn_tdst_rdy_n,
        output trn_tdst_dsc_n
    );

endinterface

// File: rtl/rx_mem_rd_cpl_tlp_cpl_hdr.sv
// Combinational formatter for the two 64-bit completion beats (CplD or UR Cpl).
module tlp_cpl_hdr
    import rx_mem_rd_cpl_pkg::*;
(
    input  req_fields_t req,
    input  logic [4:0]  lower_addr_dw,
    input  logic [2:0]  status,
    input  logic [15:0] completer_id,
    input  logic [31:0] rd_data,
    output logic [63:0] beat0,
    output logic [63:0] beat1,
    output logic [7:0]  beat1_rem_n
);

    logic        ur;
    logic [6:0]  fmt_type;
    logic [9:0]  length;
    logic [11:0] byte_count;
    logic [6:0]  lower_addr;
    logic [31:0] data_le;

    always_comb begin
        ur         = (status != SC);
        fmt_type   = ur ? CPL_NO_DATA_FMT_TYPE : CPL_W_DATA_FMT_TYPE;
        length     = ur ? 10'd0 : 10'd1;
        byte_count = (!ur && (req.first_be == 4'b0000)) ? 12'd1 : 12'd4;
        lower_addr = {lower_addr_dw, first_be_index(req.first_be)};
        data_le    = {rd_data[7:0], rd_data[15:8], rd_data[23:16], rd_data[31:24]};

        beat0 = {1'b0, fmt_type, 1'b0, req.tc, 4'b0000, 2'b00, req.attr, 2'b00, length,
                 completer_id, status, 1'b0, byte_count};
        // A UR completion has no payload: only header DW2 goes out on beat 1.
        beat1       = {req.req_id, req.tag, 1'b0, lower_addr, ur ? 32'h0 : data_le};
        beat1_rem_n = ur ? 8'h0F : 8'h00;
    end

endmodule

// File: rtl/rx_mem_rd_cpl.sv
// Target completer: decodes MRd32/MRd64 to BAR0, reads one register DW and
// returns a CplD (or UR Cpl) over the shared TRN transmit path.
module rx_mem_rd_cpl
    import rx_mem_rd_cpl_pkg::*;
#(
    parameter logic [6:0]  BAR_MASK = BAR0_MASK,
    parameter int unsigned REG_AW   = 10
) (
    input  logic              trn_clk,
    input  logic              reset,

    input  logic [63:0]       trn_rd,
    input  logic [7:0]        trn_rrem_n,
    input  logic              trn_rsof_n,
    input  logic              trn_reof_n,
    input  logic              trn_rsrc_rdy_n,
    input  logic              trn_rdst_rdy_n,
    input  logic [6:0]        trn_rbar_hit_n,
    output logic              trn_rnp_ok_n,

    input  logic [15:0]       cfg_completer_id,

    output logic              reg_rd_en,
    output logic [REG_AW-1:0] reg_rd_addr,
    input  logic [31:0]       reg_rd_data,

    rx_mem_rd_cpl_if.master   tx
);

    state_t      state;
    req_fields_t req;
    logic [2:0]  status;
    logic [31:0] rd_data;

    logic        rx_beat;
    logic [6:0]  rx_fmt_type;
    logic        sof_match;
    logic [29:0] rx_addr;

    logic [63:0] beat0;
    logic [63:0] beat1;
    logic [7:0]  beat1_rem_n;

    logic        unused_ok;

    always_comb begin
        rx_beat     = !trn_rsrc_rdy_n && !trn_rdst_rdy_n;
        rx_fmt_type = trn_rd[62:56];
        sof_match   = rx_beat && !trn_rsof_n
                      && ((rx_fmt_type == MRD32) || (rx_fmt_type == MRD64))
                      && ((~trn_rbar_hit_n & ~BAR_MASK) != '0);
        rx_addr     = req.is_64 ? trn_rd[31:2] : trn_rd[63:34];
    end

    // Monitored-only stream fields and address bits beyond the register window.
    assign unused_ok = &{1'b0, trn_rd, trn_rrem_n, trn_reof_n, rx_addr};

    tlp_cpl_hdr u_cpl_hdr (
        .req           (req),
        .lower_addr_dw (reg_rd_addr[4:0]),
        .status        (status),
        .completer_id  (cfg_completer_id),
        .rd_data       (rd_data),
        .beat0         (beat0),
        .beat1         (beat1),
        .beat1_rem_n   (beat1_rem_n)
    );

    always_ff @(posedge trn_clk) begin
        if (reset) begin
            state             <= ST_IDLE;
            req               <= '0;
            status            <= SC;
            rd_data           <= '0;
            reg_rd_addr       <= '0;
            reg_rd_en         <= 1'b0;
            trn_rnp_ok_n      <= 1'b0;
            tx.tx_req         <= 1'b0;
            tx.trn_td         <= '0;
            tx.trn_trem_n     <= '1;
            tx.trn_tsof_n     <= 1'b1;
            tx.trn_teof_n     <= 1'b1;
            tx.trn_tsrc_rdy_n <= 1'b1;
        end else begin
            reg_rd_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (sof_match) begin
                        req.tc       <= trn_rd[54:52];
                        req.attr     <= trn_rd[45:44];
                        req.length   <= trn_rd[41:32];
                        req.req_id   <= trn_rd[31:16];
                        req.tag      <= trn_rd[15:8];
                        req.first_be <= trn_rd[3:0];
                        req.is_64    <= (rx_fmt_type == MRD64);
                        trn_rnp_ok_n <= 1'b1;
                        state        <= ST_HDR2;
                    end
                end
                ST_HDR2: begin
                    if (rx_beat) begin
                        reg_rd_addr <= rx_addr[REG_AW-1:0];
                        tx.tx_req   <= 1'b1;
                        if (req.length == 10'd1) begin
                            status    <= SC;
                            reg_rd_en <= 1'b1;
                            state     <= ST_RD;
                        end else begin
                            status <= UR;
                            state  <= ST_REQ;
                        end
                    end
                end
                ST_RD: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Beat 0 needs no read data, so a held grant lets SOF go out
                    // while the data register is loading.
                    rd_data <= reg_rd_data;
                    if (tx.tx_gnt) begin
                        tx.trn_td         <= beat0;
                        tx.trn_trem_n     <= 8'h00;
                        tx.trn_tsof_n     <= 1'b0;
                        tx.trn_teof_n     <= 1'b1;
                        tx.trn_tsrc_rdy_n <= 1'b0;
                        state             <= ST_B0;
                    end else begin
                        state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (tx.tx_gnt) begin
                        tx.trn_td         <= beat0;
                        tx.trn_trem_n     <= 8'h00;
                        tx.trn_tsof_n     <= 1'b0;
                        tx.trn_teof_n     <= 1'b1;
                        tx.trn_tsrc_rdy_n <= 1'b0;
                        state             <= ST_B0;
                    end
                end
                ST_B0: begin
                    if (!tx.trn_tdst_dsc_n) begin
                        tx.trn_td         <= '0;
                        tx.trn_trem_n     <= '1;
                        tx.trn_tsof_n     <= 1'b1;
                        tx.trn_teof_n     <= 1'b1;
                        tx.trn_tsrc_rdy_n <= 1'b1;
                        tx.tx_req         <= 1'b0;
                        trn_rnp_ok_n      <= 1'b0;
                        state             <= ST_IDLE;
                    end else if (!tx.trn_tdst_rdy_n) begin
                        tx.trn_td     <= beat1;
                        tx.trn_trem_n <= beat1_rem_n;
                        tx.trn_tsof_n <= 1'b1;
                        tx.trn_teof_n <= 1'b0;
                        state         <= ST_B1;
                    end
                end
                ST_B1: begin
                    if (!tx.trn_tdst_dsc_n || !tx.trn_tdst_rdy_n) begin
                        tx.trn_td         <= '0;
                        tx.trn_trem_n     <= '1;
                        tx.trn_tsof_n     <= 1'b1;
                        tx.trn_teof_n     <= 1'b1;
                        tx.trn_tsrc_rdy_n <= 1'b1;
                        tx.tx_req         <= 1'b0;
                        trn_rnp_ok_n      <= 1'b0;
                        state             <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_mem_rd_cpl.sv
// Directed bench for rx_mem_rd_cpl: register reads, UR path, filtering,
// grant/ready stalls, discontinue and reset recovery.
`timescale 1ns/1ps
module tb_rx_mem_rd_cpl;

    logic        trn_clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] trn_rd = '0;
    logic [7:0]  trn_rrem_n = 8'hFF;
    logic        trn_rsof_n = 1'b1;
    logic        trn_reof_n = 1'b1;
    logic        trn_rsrc_rdy_n = 1'b1;
    logic        trn_rdst_rdy_n = 1'b0;
    logic [6:0]  trn_rbar_hit_n = 7'h7F;
    logic        trn_rnp_ok_n;
    logic [15:0] cfg_completer_id = 16'h0100;
    logic        reg_rd_en;
    logic [9:0]  reg_rd_addr;
    logic [31:0] reg_rd_data = '0;

    rx_mem_rd_cpl_if tx_if ();

    rx_mem_rd_cpl #(.BAR_MASK(7'b1111110), .REG_AW(10)) dut (
        .trn_clk          (trn_clk),
        .reset            (reset),
        .trn_rd           (trn_rd),
        .trn_rrem_n       (trn_rrem_n),
        .trn_rsof_n       (trn_rsof_n),
        .trn_reof_n       (trn_reof_n),
        .trn_rsrc_rdy_n   (trn_rsrc_rdy_n),
        .trn_rdst_rdy_n   (trn_rdst_rdy_n),
        .trn_rbar_hit_n   (trn_rbar_hit_n),
        .trn_rnp_ok_n     (trn_rnp_ok_n),
        .cfg_completer_id (cfg_completer_id),
        .reg_rd_en        (reg_rd_en),
        .reg_rd_addr      (reg_rd_addr),
        .reg_rd_data      (reg_rd_data),
        .tx               (tx_if.master)
    );

    always #5 trn_clk = ~trn_clk;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] reg_val = '0;
    int          rd_en_count = 0;
    int          beat_count = 0;
    int          activity = 0;
    logic [63:0] cap_td  [0:7];
    logic [7:0]  cap_rem [0:7];
    logic [1:0]  cap_se  [0:7];

    // Register file returns data exactly one cycle after the strobe, garbage otherwise.
    always @(posedge trn_clk) begin
        reg_rd_data <= reg_rd_en ? reg_val : 32'hBAD0BAD0;
        if (reg_rd_en) rd_en_count <= rd_en_count + 1;
        if (reg_rd_en || tx_if.tx_req || !tx_if.trn_tsrc_rdy_n || trn_rnp_ok_n)
            activity <= activity + 1;
        if (!tx_if.trn_tsrc_rdy_n && !tx_if.trn_tdst_rdy_n && tx_if.trn_tdst_dsc_n) begin
            cap_td[beat_count % 8]  <= tx_if.trn_td;
            cap_rem[beat_count % 8] <= tx_if.trn_trem_n;
            cap_se[beat_count % 8]  <= {tx_if.trn_tsof_n, tx_if.trn_teof_n};
            beat_count <= beat_count + 1;
        end
    end

    initial begin
        tx_if.tx_gnt         = 1'b1;
        tx_if.trn_tdst_rdy_n = 1'b0;
        tx_if.trn_tdst_dsc_n = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(posedge trn_clk);
        #1;
    endtask

    function automatic logic [63:0] mk_hdr(input logic [6:0] ft, input logic [2:0] tc,
                                           input logic [1:0] attr, input logic [9:0] len,
                                           input logic [15:0] rid, input logic [7:0] tag,
                                           input logic [3:0] be);
        logic [63:0] h;
        h = '0;
        h[62:56] = ft;
        h[54:52] = tc;
        h[45:44] = attr;
        h[41:32] = len;
        h[31:16] = rid;
        h[15:8]  = tag;
        h[7:4]   = (len == 10'd1) ? 4'h0 : 4'hF;
        h[3:0]   = be;
        return h;
    endfunction

    function automatic logic [63:0] mk_a32(input logic [31:0] a);
        return {a[31:2], 2'b00, 32'h0};
    endfunction

    task automatic send_tlp(input logic [63:0] h0, input logic [63:0] h1,
                            input logic [6:0] bar, input logic [7:0] rem1,
                            output logic rnp_after_sof);
        trn_rd = h0; trn_rbar_hit_n = bar; trn_rrem_n = 8'h00;
        trn_rsof_n = 1'b0; trn_reof_n = 1'b1; trn_rsrc_rdy_n = 1'b0;
        step(1);
        rnp_after_sof = trn_rnp_ok_n;
        trn_rd = h1; trn_rbar_hit_n = 7'h7F; trn_rrem_n = rem1;
        trn_rsof_n = 1'b1; trn_reof_n = 1'b0;
        step(1);
        trn_rsrc_rdy_n = 1'b1; trn_reof_n = 1'b1; trn_rd = '0; trn_rrem_n = 8'hFF;
    endtask

    task automatic wait_beats(input int target, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (beat_count >= target) begin ok = 1'b1; break; end
            step(1);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(2);
        vectors++; if (trn_rnp_ok_n !== 1'b0) begin miscompares++; $display("FAIL reset_rnp: got %b want 0", trn_rnp_ok_n); end
        vectors++; if ({reg_rd_en, tx_if.tx_req} !== 2'b00) begin miscompares++; $display("FAIL reset_req: got %b want 00", {reg_rd_en, tx_if.tx_req}); end
        vectors++; if ({tx_if.trn_tsof_n, tx_if.trn_teof_n, tx_if.trn_tsrc_rdy_n} !== 3'b111) begin miscompares++; $display("FAIL reset_ctl: got %b want 111", {tx_if.trn_tsof_n, tx_if.trn_teof_n, tx_if.trn_tsrc_rdy_n}); end
        vectors++; if ({tx_if.trn_td, tx_if.trn_trem_n} !== {64'h0, 8'hFF}) begin miscompares++; $display("FAIL reset_td: got %h/%h want 0/ff", tx_if.trn_td, tx_if.trn_trem_n); end
        reset = 1'b0;
        step(1);
    endtask

    task automatic test_mrd32_sc();
        logic rnp; int rd0;
        tx_if.tx_gnt = 1'b1; tx_if.trn_tdst_rdy_n = 1'b0;
        reg_val = 32'h11223344; rd0 = rd_en_count;
        send_tlp(mk_hdr(7'h00, 3'd0, 2'd0, 10'd1, 16'hABCD, 8'h05, 4'hF), mk_a32(32'h10), 7'b1111110, 8'h0F, rnp);
        vectors++; if (rnp !== 1'b1) begin miscompares++; $display("FAIL sc_rnp_sof: got %b want 1", rnp); end
        vectors++; if ({reg_rd_en, tx_if.tx_req, reg_rd_addr} !== {2'b11, 10'd4}) begin miscompares++; $display("FAIL sc_rd_e1: got %b %b %h want 1 1 004", reg_rd_en, tx_if.tx_req, reg_rd_addr); end
        step(1);
        vectors++; if ({reg_rd_en, tx_if.trn_tsrc_rdy_n} !== 2'b01) begin miscompares++; $display("FAIL sc_e2: got %b want 01", {reg_rd_en, tx_if.trn_tsrc_rdy_n}); end
        step(1);
        vectors++; if ({tx_if.trn_tsof_n, tx_if.trn_teof_n, tx_if.trn_tsrc_rdy_n, tx_if.trn_td, tx_if.trn_trem_n} !== {3'b010, 64'h4A000001_01000004, 8'h00})
            begin miscompares++; $display("FAIL sc_beat0: got %b%b%b %h %h want 010 4a00000101000004 00", tx_if.trn_tsof_n, tx_if.trn_teof_n, tx_if.trn_tsrc_rdy_n, tx_if.trn_td, tx_if.trn_trem_n); end
        step(1);
        vectors++; if ({tx_if.trn_tsof_n, tx_if.trn_teof_n, tx_if.trn_tsrc_rdy_n, tx_if.trn_td, tx_if.trn_trem_n, trn_rnp_ok_n} !== {3'b100, 64'hABCD0510_44332211, 8'h00, 1'b1})
            begin miscompares++; $display("FAIL sc_beat1: got %b%b%b %h %h rnp=%b want 100 abcd051044332211 00 rnp=1", tx_if.trn_tsof_n, tx_if.trn_teof_n, tx_if.trn_tsrc_rdy_n, tx_if.trn_td, tx_if.trn_trem_n, trn_rnp_ok_n); end
        step(1);
        vectors++; if ({tx_if.trn_tsrc_rdy_n, trn_rnp_ok_n, tx_if.tx_req} !== 3'b100) begin miscompares++; $display("FAIL sc_done: got %b want 100", {tx_if.trn_tsrc_rdy_n, trn_rnp_ok_n, tx_if.tx_req}); end
        vectors++; if (rd_en_count - rd0 !== 1) begin miscompares++; $display("FAIL sc_rd_once: got %0d want 1", rd_en_count - rd0); end
        step(2);
    endtask

    task automatic test_mrd64();
        logic rnp, ok; int b0;
        reg_val = 32'hDEADBEEF; b0 = beat_count;
        send_tlp(mk_hdr(7'h20, 3'd2, 2'd1, 10'd1, 16'h1234, 8'h22, 4'hF), 64'h00000001_00000F04, 7'b1111110, 8'h00, rnp);
        vectors++; if ({reg_rd_en, reg_rd_addr} !== {1'b1, 10'h3C1}) begin miscompares++; $display("FAIL m64_addr: got %b %h want 1 3c1", reg_rd_en, reg_rd_addr); end
        wait_beats(b0 + 2, ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL m64_timeout: got %0d beats want 2", beat_count - b0); end
        vectors++; if ({cap_se[b0 % 8], cap_td[b0 % 8]} !== {2'b01, 64'h4A201001_01000004}) begin miscompares++; $display("FAIL m64_beat0: got %b %h want 01 4a20100101000004", cap_se[b0 % 8], cap_td[b0 % 8]); end
        vectors++; if ({cap_se[(b0 + 1) % 8], cap_td[(b0 + 1) % 8]} !== {2'b10, 64'h12342204_EFBEADDE}) begin miscompares++; $display("FAIL m64_beat1: got %b %h want 10 12342204efbeadde", cap_se[(b0 + 1) % 8], cap_td[(b0 + 1) % 8]); end
        step(2);
    endtask

    task automatic test_byte_enables();
        logic rnp, ok; int b0;
        reg_val = 32'h01020304; b0 = beat_count;
        send_tlp(mk_hdr(7'h00, 3'd0, 2'd0, 10'd1, 16'hABCD, 8'h07, 4'h0), mk_a32(32'h24), 7'b1111110, 8'h0F, rnp);
        wait_beats(b0 + 2, ok);
        vectors++; if ({cap_td[b0 % 8], cap_td[(b0 + 1) % 8]} !== {64'h4A000001_01000001, 64'hABCD0724_04030201})
            begin miscompares++; $display("FAIL be_zero: got %h %h want 4a00000101000001 abcd072404030201", cap_td[b0 % 8], cap_td[(b0 + 1) % 8]); end
        step(2);
        reg_val = 32'hA5A50F0F; b0 = beat_count;
        send_tlp(mk_hdr(7'h00, 3'd0, 2'd0, 10'd1, 16'hABCD, 8'h08, 4'hC), mk_a32(32'h08), 7'b1111110, 8'h0F, rnp);
        wait_beats(b0 + 2, ok);
        vectors++; if ({cap_td[b0 % 8], cap_td[(b0 + 1) % 8]} !== {64'h4A000001_01000004, 64'hABCD080A_0F0FA5A5})
            begin miscompares++; $display("FAIL be_1100: got %h %h want 4a00000101000004 abcd080a0f0fa5a5", cap_td[b0 % 8], cap_td[(b0 + 1) % 8]); end
        step(2);
    endtask

    task automatic test_ur_length();
        logic rnp, ok; int b0, rd0;
        b0 = beat_count; rd0 = rd_en_count;
        send_tlp(mk_hdr(7'h00, 3'd0, 2'd0, 10'd2, 16'h5555, 8'h33, 4'hF), mk_a32(32'h40), 7'b1111110, 8'h0F, rnp);
        vectors++; if ({reg_rd_en, tx_if.tx_req} !== 2'b01) begin miscompares++; $display("FAIL ur_e1: got %b want 01", {reg_rd_en, tx_if.tx_req}); end
        wait_beats(b0 + 2, ok);
        vectors++; if ({cap_td[b0 % 8], cap_rem[b0 % 8]} !== {64'h0A000000_01002004, 8'h00}) begin miscompares++; $display("FAIL ur_beat0: got %h %h want 0a00000001002004 00", cap_td[b0 % 8], cap_rem[b0 % 8]); end
        vectors++; if ({cap_td[(b0 + 1) % 8][63:32], cap_rem[(b0 + 1) % 8]} !== {32'h55553340, 8'h0F}) begin miscompares++; $display("FAIL ur_beat1: got %h %h want 55553340 0f", cap_td[(b0 + 1) % 8][63:32], cap_rem[(b0 + 1) % 8]); end
        step(1);
        vectors++; if ({rd_en_count - rd0, trn_rnp_ok_n} !== {32'd0, 1'b0}) begin miscompares++; $display("FAIL ur_no_read: got rd=%0d rnp=%b want 0 0", rd_en_count - rd0, trn_rnp_ok_n); end
        step(2);
    endtask

    task automatic test_ignored();
        logic rnp; int a0;
        a0 = activity;
        send_tlp(mk_hdr(7'h00, 3'd0, 2'd0, 10'd1, 16'h0001, 8'h09, 4'hF), mk_a32(32'h10), 7'b1111101, 8'h0F, rnp);
        step(10);
        vectors++; if ({activity - a0, rnp} !== {32'd0, 1'b0}) begin miscompares++; $display("FAIL ign_bar1: got act=%0d rnp=%b want 0 0", activity - a0, rnp); end
        a0 = activity;
        send_tlp(mk_hdr(7'h40, 3'd0, 2'd0, 10'd1, 16'h0001, 8'h0A, 4'hF), {32'h00000010, 32'h12345678}, 7'b1111110, 8'h00, rnp);
        step(10);
        vectors++; if ({activity - a0, rnp} !== {32'd0, 1'b0}) begin miscompares++; $display("FAIL ign_mwr: got act=%0d rnp=%b want 0 0", activity - a0, rnp); end
    endtask

    task automatic test_gnt_hold();
        logic rnp; int b0, bad; logic [63:0] held;
        tx_if.tx_gnt = 1'b0; reg_val = 32'h55AA00FF; b0 = beat_count; bad = 0;
        send_tlp(mk_hdr(7'h00, 3'd0, 2'd0, 10'd1, 16'h0F0F, 8'h11, 4'hF), mk_a32(32'h100), 7'b1111110, 8'h0F, rnp);
        for (int i = 0; i < 20; i++) begin
            if (tx_if.trn_tsrc_rdy_n !== 1'b1 || tx_if.tx_req !== 1'b1) bad++;
            step(1);
        end
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL gnt_low_idle: got %0d bad cycles want 0", bad); end
        tx_if.tx_gnt = 1'b1; tx_if.trn_tdst_rdy_n = 1'b1;
        step(1);
        held = tx_if.trn_td;
        step(2);
        vectors++; if ({tx_if.trn_tsrc_rdy_n, tx_if.trn_tsof_n, tx_if.trn_td} !== {2'b00, 64'h4A000001_01000004}) begin miscompares++; $display("FAIL hold_b0: got %b%b %h want 00 4a00000101000004", tx_if.trn_tsrc_rdy_n, tx_if.trn_tsof_n, tx_if.trn_td); end
        vectors++; if (tx_if.trn_td !== held) begin miscompares++; $display("FAIL hold_b0_stable: got %h want %h", tx_if.trn_td, held); end
        tx_if.trn_tdst_rdy_n = 1'b0;
        step(1);
        tx_if.trn_tdst_rdy_n = 1'b1;
        step(2);
        vectors++; if ({tx_if.trn_tsrc_rdy_n, tx_if.trn_teof_n, tx_if.trn_td} !== {2'b00, 64'h0F0F1100_FF00AA55}) begin miscompares++; $display("FAIL hold_b1: got %b%b %h want 00 0f0f1100ff00aa55", tx_if.trn_tsrc_rdy_n, tx_if.trn_teof_n, tx_if.trn_td); end
        tx_if.trn_tdst_rdy_n = 1'b0;
        step(1);
        vectors++; if ({tx_if.trn_tsrc_rdy_n, trn_rnp_ok_n} !== 2'b10) begin miscompares++; $display("FAIL hold_done: got %b want 10", {tx_if.trn_tsrc_rdy_n, trn_rnp_ok_n}); end
        step(3);
        vectors++; if (beat_count - b0 !== 2) begin miscompares++; $display("FAIL hold_once: got %0d beats want 2", beat_count - b0); end
        vectors++; if ({cap_td[b0 % 8], cap_td[(b0 + 1) % 8]} !== {64'h4A000001_01000004, 64'h0F0F1100_FF00AA55}) begin miscompares++; $display("FAIL hold_cap: got %h %h", cap_td[b0 % 8], cap_td[(b0 + 1) % 8]); end
    endtask

    task automatic test_discontinue();
        logic rnp, ok; int b0;
        tx_if.tx_gnt = 1'b1; tx_if.trn_tdst_rdy_n = 1'b1; b0 = beat_count; ok = 1'b0;
        send_tlp(mk_hdr(7'h00, 3'd0, 2'd0, 10'd1, 16'hABCD, 8'h12, 4'hF), mk_a32(32'h14), 7'b1111110, 8'h0F, rnp);
        for (int i = 0; i < 10; i++) begin
            if (tx_if.trn_tsrc_rdy_n === 1'b0) begin ok = 1'b1; break; end
            step(1);
        end
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL dsc_timeout: got no SOF want SOF within 10 cycles"); end
        tx_if.trn_tdst_rdy_n = 1'b0;
        step(1);
        tx_if.trn_tdst_rdy_n = 1'b1; tx_if.trn_tdst_dsc_n = 1'b0;
        step(1);
        tx_if.trn_tdst_dsc_n = 1'b1; tx_if.trn_tdst_rdy_n = 1'b0;
        vectors++; if ({tx_if.trn_tsrc_rdy_n, trn_rnp_ok_n, tx_if.tx_req} !== 3'b100) begin miscompares++; $display("FAIL dsc_drop: got %b want 100", {tx_if.trn_tsrc_rdy_n, trn_rnp_ok_n, tx_if.tx_req}); end
        step(3);
        vectors++; if (beat_count - b0 !== 1) begin miscompares++; $display("FAIL dsc_beats: got %0d want 1", beat_count - b0); end
    endtask

    task automatic test_reset_in_wait();
        logic rnp, ok; int b0, rd0;
        tx_if.tx_gnt = 1'b0; rd0 = rd_en_count;
        send_tlp(mk_hdr(7'h00, 3'd0, 2'd0, 10'd1, 16'hABCD, 8'h21, 4'hF), mk_a32(32'h30), 7'b1111110, 8'h0F, rnp);
        step(1);
        reset = 1'b1;
        step(1);
        vectors++; if ({trn_rnp_ok_n, reg_rd_en, tx_if.tx_req, tx_if.trn_tsof_n, tx_if.trn_teof_n, tx_if.trn_tsrc_rdy_n} !== 6'b000111) begin miscompares++; $display("FAIL rstw_ctl: got %b want 000111", {trn_rnp_ok_n, reg_rd_en, tx_if.tx_req, tx_if.trn_tsof_n, tx_if.trn_teof_n, tx_if.trn_tsrc_rdy_n}); end
        vectors++; if ({tx_if.trn_td, tx_if.trn_trem_n} !== {64'h0, 8'hFF}) begin miscompares++; $display("FAIL rstw_td: got %h/%h want 0/ff", tx_if.trn_td, tx_if.trn_trem_n); end
        reset = 1'b0; tx_if.tx_gnt = 1'b1; reg_val = 32'hCAFEF00D;
        step(1);
        b0 = beat_count;
        send_tlp(mk_hdr(7'h00, 3'd0, 2'd0, 10'd1, 16'hABCD, 8'h44, 4'hF), mk_a32(32'h0C), 7'b1111110, 8'h0F, rnp);
        vectors++; if (rnp !== 1'b1) begin miscompares++; $display("FAIL rstw_rnp: got %b want 1", rnp); end
        wait_beats(b0 + 2, ok);
        vectors++; if ({ok, cap_td[(b0 + 1) % 8]} !== {1'b1, 64'hABCD440C_0DF0FECA}) begin miscompares++; $display("FAIL rstw_next: got ok=%b %h want 1 abcd440c0df0feca", ok, cap_td[(b0 + 1) % 8]); end
        vectors++; if (rd_en_count - rd0 !== 2) begin miscompares++; $display("FAIL rstw_reads: got %0d want 2", rd_en_count - rd0); end
        step(2);
    endtask

    initial begin
        test_reset();
        test_mrd32_sc();
        test_mrd64();
        test_byte_enables();
        test_ur_length();
        test_ignored();
        test_gnt_hold();
        test_discontinue();
        test_reset_in_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
